// File: rtl/nrzi_rx_decoder.sv
// USB receive-side NRZI decoder: recovers data bits from J/K line samples,
// strips stuffed zeros, flags stuffing violations and detects SE0,SE0,J end-of-packet.
module nrzi_rx_decoder #(
  parameter int STUFF_LEN = 6
) (
  input  logic clock,
  input  logic reset,
  input  logic in_valid,
  input  logic in_bit,
  input  logic in_se0,
  output logic out_bit,
  output logic out_valid,
  output logic eop,
  output logic stuff_err,
  output logic eop_err,
  output logic nrzi_receiving
);

  localparam int CW = $clog2(STUFF_LEN + 1);
  localparam logic [CW-1:0] STUFF_MAX = CW'(STUFF_LEN);

  typedef enum logic [1:0] {IDLE, RECV, EOP1, EOP2} state_t;

  state_t        state_reg, state_next;
  logic          prev_reg, prev_next;
  logic [CW-1:0] ones_reg, ones_next;
  logic          out_bit_next, out_valid_next, eop_next, stuff_err_next, eop_err_next;
  logic          dec;

  assign dec = ~(in_bit ^ prev_reg);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      prev_reg       <= 1'b1;
      ones_reg       <= '0;
      out_bit        <= 1'b0;
      out_valid      <= 1'b0;
      eop            <= 1'b0;
      stuff_err      <= 1'b0;
      eop_err        <= 1'b0;
      nrzi_receiving <= 1'b0;
    end else begin
      state_reg      <= state_next;
      prev_reg       <= prev_next;
      ones_reg       <= ones_next;
      out_bit        <= out_bit_next;
      out_valid      <= out_valid_next;
      eop            <= eop_next;
      stuff_err      <= stuff_err_next;
      eop_err        <= eop_err_next;
      nrzi_receiving <= (state_next != IDLE);
    end
  end

  always_comb begin
    state_next     = state_reg;
    prev_next      = prev_reg;
    ones_next      = ones_reg;
    out_bit_next   = 1'b0;
    out_valid_next = 1'b0;
    eop_next       = 1'b0;
    stuff_err_next = 1'b0;
    eop_err_next   = 1'b0;

    if (in_valid) begin
      // Every non-SE0 sample refreshes the reference level, even a dropped stuff bit.
      if (!in_se0) prev_next = in_bit;

      unique case (state_reg)
        IDLE: begin
          if (!in_se0) begin
            ones_next  = '0;
            state_next = RECV;
          end
        end
        RECV: begin
          if (in_se0) begin
            ones_next  = '0;
            state_next = EOP1;
          end else if (ones_reg == STUFF_MAX) begin
            ones_next = '0;
            if (dec) begin
              stuff_err_next = 1'b1;
              state_next     = IDLE;
            end
          end else begin
            out_valid_next = 1'b1;
            out_bit_next   = dec;
            ones_next      = dec ? ones_reg + 1'b1 : '0;
          end
        end
        EOP1: begin
          if (in_se0) begin
            state_next = EOP2;
          end else begin
            eop_err_next = 1'b1;
            state_next   = IDLE;
          end
        end
        EOP2: begin
          if (!in_se0) begin
            if (in_bit) eop_next = 1'b1;
            else        eop_err_next = 1'b1;
            prev_next  = 1'b1;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nrzi_rx_decoder.sv
// Directed self-checking bench for nrzi_rx_decoder; one line per sample transaction.
module tb_nrzi_rx_decoder;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic in_bit = 1'b1;
  logic in_se0 = 1'b0;
  logic out_bit, out_valid, eop, stuff_err, eop_err, nrzi_receiving;

  int checks = 0;
  int failures = 0;

  // Expected output vectors: {out_valid, out_bit&out_valid, eop, stuff_err, eop_err, nrzi_receiving}
  localparam logic [5:0] E_NONE = 6'b000000;
  localparam logic [5:0] E_RX   = 6'b000001;
  localparam logic [5:0] E_ONE  = 6'b110001;
  localparam logic [5:0] E_ZERO = 6'b100001;
  localparam logic [5:0] E_EOP  = 6'b001000;
  localparam logic [5:0] E_SERR = 6'b000100;
  localparam logic [5:0] E_EERR = 6'b000010;

  nrzi_rx_decoder #(.STUFF_LEN(6)) dut (
    .clock(clock),
    .reset(reset),
    .in_valid(in_valid),
    .in_bit(in_bit),
    .in_se0(in_se0),
    .out_bit(out_bit),
    .out_valid(out_valid),
    .eop(eop),
    .stuff_err(stuff_err),
    .eop_err(eop_err),
    .nrzi_receiving(nrzi_receiving)
  );

  always #5 clock = ~clock;

  function automatic logic [5:0] observed();
    return {out_valid, out_bit & out_valid, eop, stuff_err, eop_err, nrzi_receiving};
  endfunction

  task automatic check_eq(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end else begin
      $display("ok   %s: %b", tag, obs);
    end
  endtask

  // Drive one cycle of input at the falling edge, check the response just after the rising edge.
  task automatic step(input string tag, input logic v, input logic b, input logic s,
                      input logic [5:0] exp);
    @(negedge clock);
    in_valid = v;
    in_bit   = b;
    in_se0   = s;
    @(posedge clock);
    #1;
    check_eq(tag, observed(), exp);
  endtask

  task automatic j_samp(input string tag, input logic [5:0] exp);
    step(tag, 1'b1, 1'b1, 1'b0, exp);
  endtask

  task automatic k_samp(input string tag, input logic [5:0] exp);
    step(tag, 1'b1, 1'b0, 1'b0, exp);
  endtask

  task automatic se0_samp(input string tag, input logic [5:0] exp);
    step(tag, 1'b1, 1'b1, 1'b1, exp);
  endtask

  task automatic gap(input string tag, input logic [5:0] exp);
    step(tag, 1'b0, 1'b0, 1'b0, exp);
  endtask

  task automatic do_reset();
    @(negedge clock);
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    check_eq("reset_outputs", observed(), E_NONE);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    check_eq("reset_state", observed(), E_NONE);
    @(negedge clock);
    reset = 1'b0;

    // SE0 while idle is ignored
    se0_samp("idle_se0", E_NONE);

    // Basic decode: J ref, J K K J -> 1 0 1 0
    j_samp("basic_ref", E_RX);
    j_samp("basic_b0", E_ONE);
    k_samp("basic_b1", E_ZERO);
    k_samp("basic_b2", E_ONE);
    j_samp("basic_b3", E_ZERO);
    gap("basic_idle_gap", E_RX);

    // Stuff removal: J ref, J x6, K dropped, J -> 0
    do_reset();
    j_samp("stuff_ref", E_RX);
    for (int i = 0; i < 6; i++) j_samp($sformatf("stuff_one%0d", i), E_ONE);
    k_samp("stuff_drop", E_RX);
    j_samp("stuff_after", E_ZERO);

    // Stuff violation: J ref, J x7
    do_reset();
    j_samp("viol_ref", E_RX);
    for (int i = 0; i < 6; i++) j_samp($sformatf("viol_one%0d", i), E_ONE);
    j_samp("viol_err", E_SERR);
    gap("viol_idle", E_NONE);
    // next sample is a new reference
    k_samp("viol_restart_ref", E_RX);
    k_samp("viol_restart_b0", E_ONE);

    // EOP: SE0 SE0 SE0 J
    se0_samp("eop_se0a", E_RX);
    se0_samp("eop_se0b", E_RX);
    se0_samp("eop_se0c", E_RX);
    j_samp("eop_j", E_EOP);
    gap("eop_idle", E_NONE);

    // Malformed EOP: SE0, K
    j_samp("eerr1_ref", E_RX);
    j_samp("eerr1_b0", E_ONE);
    se0_samp("eerr1_se0", E_RX);
    k_samp("eerr1_k", E_EERR);

    // Malformed EOP: SE0, SE0, K
    j_samp("eerr2_ref", E_RX);
    se0_samp("eerr2_se0a", E_RX);
    se0_samp("eerr2_se0b", E_RX);
    k_samp("eerr2_k", E_EERR);
    gap("eerr2_idle", E_NONE);

    // Gaps: J, K, K with 3 idle cycles between samples
    do_reset();
    j_samp("gap_ref", E_RX);
    for (int i = 0; i < 3; i++) gap($sformatf("gap_a%0d", i), E_RX);
    k_samp("gap_b0", E_ZERO);
    for (int i = 0; i < 3; i++) gap($sformatf("gap_b%0d", i), E_RX);
    k_samp("gap_b1", E_ONE);

    // Asynchronous reset mid-packet with ones = 4
    do_reset();
    j_samp("mid_ref", E_RX);
    for (int i = 0; i < 4; i++) j_samp($sformatf("mid_one%0d", i), E_ONE);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_eq("mid_async_reset", observed(), E_NONE);
    @(negedge clock);
    reset = 1'b0;
    j_samp("post_ref", E_RX);
    // six full 1s before a violation proves the ones count restarted at zero
    for (int i = 0; i < 6; i++) j_samp($sformatf("post_one%0d", i), E_ONE);
    j_samp("post_viol", E_SERR);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/nrzi_rx_decoder.md
Name: nrzi_rx_decoder

Overview:
Receive-side counterpart of the NRZI encoder in the USB serial path. It takes line samples that have already been resolved to a J/K level plus an SE0 flag, and recovers the data bits through NRZI decoding. It also removes stuffed bits, flags bit-stuff violations, and detects end-of-packet (SE0, SE0, J). Its output feeds the bit-level packet receiver / shift register.

Parameters:
STUFF_LEN, 6, number of consecutive decoded 1s after which the next decoded bit must be a stuffed 0.

Ports:
clock  input  1  system clock; all state changes on posedge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  qualifies in_bit/in_se0 for one sample this cycle; state holds when low
in_bit  input  1  line level, 1 = J, 0 = K; ignored when in_se0 = 1
in_se0  input  1  1 = both lines low (SE0) this sample
out_bit  output  1  decoded data bit; meaningful only when out_valid = 1
out_valid  output  1  one-cycle pulse per delivered (non-stuffed) data bit
eop  output  1  one-cycle pulse on a valid end-of-packet
stuff_err  output  1  one-cycle pulse on a bit-stuff violation
eop_err  output  1  one-cycle pulse on a malformed EOP
nrzi_receiving  output  1  high while in RECV, EOP1 or EOP2

Behaviour:
- Registers: state, prev (last line level), ones count (width clog2(STUFF_LEN+1)). All outputs are registered.
- Reset (asserted at any time, including mid-packet):
  - state = IDLE, prev = 1, ones = 0.
  - All outputs = 0.
  - Takes effect immediately; no pulse is emitted for an aborted packet.
- Latency: the response to a sample accepted on edge N appears on outputs from edge N until edge N+1 (exactly one cycle). The pulse outputs (out_valid, eop, stuff_err, eop_err) are 0 in every other cycle.
- in_valid = 0: no state, prev or count change, and all pulse outputs are 0 next cycle.
- Decode rule: dec = ~(in_bit ^ prev). Same level gives 1; a transition gives 0. prev <= in_bit on every accepted non-SE0 sample.
- IDLE:
  - SE0 sample: stay in IDLE.
  - Non-SE0 sample: prev <= in_bit, ones <= 0, go to RECV.
  - This first sample only establishes the reference level; no out_valid is produced.
- RECV, non-SE0 sample:
  - If ones == STUFF_LEN and dec = 0: bit dropped (no out_valid), ones <= 0.
  - If ones == STUFF_LEN and dec = 1: stuff_err pulse, go to IDLE (ones <= 0).
  - Otherwise: out_valid = 1, out_bit = dec, ones <= dec ? ones+1 : 0.
- RECV, SE0 sample: go to EOP1; ones <= 0; no output.
- EOP1:
  - SE0 sample: go to EOP2.
  - Non-SE0 sample: eop_err pulse, go to IDLE.
- EOP2:
  - SE0 sample: stay in EOP2 (extended SE0 is tolerated).
  - J sample: eop pulse, prev <= 1, go to IDLE.
  - K sample: eop_err pulse, go to IDLE.
- Simultaneous events: at most one of out_valid/eop/stuff_err/eop_err is high in any cycle.
- A dropped stuffed 0 still updates prev.
- An error in any state returns to IDLE. The next non-SE0 sample restarts reception as a new reference sample.
- nrzi_receiving is registered from next state: high the cycle after the IDLE to RECV transition, low the cycle after return to IDLE.

Test Plan:
- Basic decode:
  - Stimulus: reset, then valid line samples J,J,K,K,J.
  - Required: first J gives no output, then out bits 1,0,1,0 on four consecutive cycles, each 1 cycle after its sample. nrzi_receiving rises after the first sample.
- Stuff removal:
  - Stimulus: J reference, then J x6, K, J.
  - Required: six out bits of 1, then no out_valid for the K, then out_bit = 0 for the J transition. No stuff_err.
- Stuff violation:
  - Stimulus: J reference, then J x7.
  - Required: six 1s, then stuff_err pulse on the 7th sample response. State is IDLE and nrzi_receiving = 0 the following cycle.
- EOP:
  - Stimulus: mid-packet, SE0, SE0, SE0, J.
  - Required: no out_valid during SE0; single eop pulse 1 cycle after the J; then IDLE.
  - Stimulus: SE0, K.
  - Required: eop_err pulse.
  - Stimulus: SE0, SE0, K.
  - Required: eop_err pulse.
- Gaps:
  - Stimulus: J,K,K with in_valid low for 3 cycles between samples.
  - Required: outputs identical to the gap-free case, and pulse outputs 0 during the gaps.
- Reset mid-operation:
  - Stimulus: assert reset asynchronously (between clock edges) during RECV with ones = 4.
  - Required: all outputs 0 immediately. After release, a J,J sequence yields a single out bit 1, confirming the count was cleared.
